mmio_responder: RTL
===================

Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the core's data-memory port. Decodes load/store addresses in the IO region driven by the execute-stage ALU result.
- Returns read data with the same 1-cycle latency as the data BRAM.
- Owns the cycle and instruction-retire counters, plus single-entry UART RX/TX holding buffers with ready/valid handshakes to the UART.

Parameters:
- DWIDTH, 32, data/address width.
- IO_BASE, 32'h8000_0000, region base; a region hit is addr[31:28] == IO_BASE[31:28].

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- addr  input  DWIDTH  byte address (ALU result) of the current memory op
- wdata  input  DWIDTH  store data
- we  input  4  store byte mask; any nonzero bit = write
- re  input  1  load request
- rdata  output  DWIDTH  registered read data, valid the cycle after re
- inst_retire  input  1  one pulse per retired instruction
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  UART has a byte
- rx_ready  output  1  responder can accept a byte
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  tx_data is pending
- tx_ready  input  1  UART accepts tx_data

Behaviour:
- Reset (sync, active-high, on clk edge): rdata=0, cycle_cnt=0, inst_cnt=0, rx_full=0, rx_byte=0, tx_full=0, tx_data=0. rst during an active handshake drops the pending byte.
- Decode: hit = region match; word offset = addr[7:0] with addr[1:0] ignored.
  - 0x00 status (RO): bit0 = !tx_full, bit1 = rx_full, others 0.
  - 0x04 RX data (RO): {24'b0, rx_byte}.
  - 0x08 TX data (WO).
  - 0x10 cycle_cnt (RO).
  - 0x14 inst_cnt (RO).
  - 0x18 counter reset (WO).
- Unmapped offsets and non-hit reads return 0; writes to them are ignored.
- Read timing: on the edge where re & hit, rdata <= the selected value, sampled from current register contents (pre-update). When re=0, rdata holds its value. Latency is exactly 1 cycle, with no backpressure.
- RX buffer:
  - rx_ready = !rx_full (combinational from state).
  - rx_valid & rx_ready: rx_byte <= rx_data, rx_full <= 1.
  - Read of 0x04 while rx_full: returns rx_byte and clears rx_full at the same edge. No accept can occur that cycle because rx_ready = 0.
  - Read of 0x04 while empty: returns the stale rx_byte; no state change.
- TX buffer:
  - tx_valid = tx_full.
  - tx_valid & tx_ready: tx_full <= 0.
  - Store to 0x08 is accepted if tx_full=0 or a handshake completes in the same cycle. On accept: tx_data <= wdata[7:0], tx_full <= 1. Otherwise the store is dropped; software polls status bit0.
  - tx_data is stable while tx_valid=1.
- Counters:
  - cycle_cnt increments every cycle.
  - inst_cnt increments on inst_retire.
  - Both are 32-bit and wrap from 0xFFFF_FFFF to 0.
  - Store to 0x18 (any data) forces both to 0 at that edge, overriding that cycle's increment.
- re and we asserted in the same cycle: both are serviced; the read returns the pre-write state.

Test Plan:
- Reset, then idle 5 cycles; load 0x8000_0010 -> rdata=5 next cycle (±pipeline offset, fixed at 5 from rst deassert edge). Load 0x8000_0000 -> 0x1 (tx empty, rx empty).
- rx_valid=1, rx_data=0x41 for 1 cycle -> rx_ready falls to 0, status reads 0x3. Load 0x8000_0004 -> rdata=0x41, rx_ready=1 next cycle. Second load -> 0x41 with status 0x1.
- Store 0x8000_0008 wdata=0x5A with tx_ready=0 -> tx_valid=1, tx_data=0x5A. Second store 0x33 is dropped. tx_ready=1 for 1 cycle -> tx_valid=0. Store 0x33 in the same cycle as the handshake -> tx_data=0x33, tx_valid stays 1.
- Pulse inst_retire 7 times over 20 cycles -> load 0x8000_0014 = 7. Store 0x8000_0018 -> immediate loads of 0x10/0x14 return 0/0, and one cycle later cycle_cnt = 1.
- Force cycle_cnt = 0xFFFF_FFFF (via run length or backdoor) -> next cycle reads 0x0000_0000.
- Load 0x8000_0020 and 0x1000_0000 -> rdata=0. Store to 0x8000_0010 -> counter unchanged. Assert rst mid-TX with tx_valid=1 -> tx_valid=0, all counters 0 after the edge.

Source files
------------

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O slave on the core's data-memory port.
// Holds the cycle/retire counters and single-entry UART RX/TX buffers.
// Read data is registered, which matches the 1-cycle latency of the data BRAM.
module mmio_responder #(
    parameter int          DWIDTH  = 32,
    parameter logic [31:0] IO_BASE = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [3:0]        we,
    input  logic              re,
    output logic [DWIDTH-1:0] rdata,
    input  logic              inst_retire,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    // Word index within the IO page (addr[7:2]); byte lanes are ignored.
    localparam logic [5:0] WORD_STATUS = 6'h00;  // 0x00
    localparam logic [5:0] WORD_RX     = 6'h01;  // 0x04
    localparam logic [5:0] WORD_TX     = 6'h02;  // 0x08
    localparam logic [5:0] WORD_CYCLE  = 6'h04;  // 0x10
    localparam logic [5:0] WORD_INST   = 6'h05;  // 0x14
    localparam logic [5:0] WORD_CLR    = 6'h06;  // 0x18

    logic [DWIDTH-1:0] rdata_reg;
    logic [31:0]       cycle_cnt_reg;
    logic [31:0]       inst_cnt_reg;
    logic              rx_full_reg;
    logic [7:0]        rx_byte_reg;
    logic              tx_full_reg;
    logic [7:0]        tx_data_reg;

    logic              hit;
    logic [5:0]        word;
    logic              wr;
    logic              rd_hit;
    logic              rx_pop;
    logic              rx_push;
    logic              tx_handshake;
    logic              tx_store;
    logic              tx_accept;
    logic              cnt_clear;
    logic [DWIDTH-1:0] rd_value;

    assign hit  = (addr[31:28] == IO_BASE[31:28]);
    assign word = addr[7:2];
    assign wr   = |we;

    assign rd_hit  = re & hit;
    // Reading RX while full consumes the byte; rx_ready is low then, so no push collides.
    assign rx_pop  = rd_hit & (word == WORD_RX) & rx_full_reg;
    assign rx_push = rx_valid & ~rx_full_reg;

    // A store lands if the slot is empty or is being drained by the UART this same edge.
    assign tx_handshake = tx_full_reg & tx_ready;
    assign tx_store     = wr & hit & (word == WORD_TX);
    assign tx_accept    = tx_store & (~tx_full_reg | tx_ready);

    assign cnt_clear = wr & hit & (word == WORD_CLR);

    assign rx_ready = ~rx_full_reg;
    assign tx_valid = tx_full_reg;
    assign tx_data  = tx_data_reg;
    assign rdata    = rdata_reg;

    // Read mux over the pre-update register contents; unmapped words read as zero.
    always_comb begin
        rd_value = '0;
        case (word)
            WORD_STATUS: rd_value = DWIDTH'({rx_full_reg, ~tx_full_reg});
            WORD_RX:     rd_value = DWIDTH'(rx_byte_reg);
            WORD_CYCLE:  rd_value = DWIDTH'(cycle_cnt_reg);
            WORD_INST:   rd_value = DWIDTH'(inst_cnt_reg);
            default:     rd_value = '0;
        endcase
    end

    // Registered read port: loads update rdata, which otherwise holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= hit ? rd_value : '0;
        end
    end

    // Free-running counters; a store to the clear word wins over the increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cycle_cnt_reg <= '0;
            inst_cnt_reg  <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            inst_cnt_reg  <= inst_cnt_reg + {31'd0, inst_retire};
        end
    end

    // RX holding buffer: filled by the UART, emptied by a load of the RX word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full_reg <= 1'b0;
            rx_byte_reg <= 8'd0;
        end else if (rx_pop) begin
            rx_full_reg <= 1'b0;
        end else if (rx_push) begin
            rx_full_reg <= 1'b1;
            rx_byte_reg <= rx_data;
        end
    end

    // TX holding buffer: filled by stores, drained by the UART handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_full_reg <= 1'b0;
            tx_data_reg <= 8'd0;
        end else if (tx_accept) begin
            tx_full_reg <= 1'b1;
            tx_data_reg <= wdata[7:0];
        end else if (tx_handshake) begin
            tx_full_reg <= 1'b0;
        end
    end

endmodule
